// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-path widths, NOP encoding and fetch FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          c_ADDR_W   = 32;
    localparam int          c_DATA_W   = 32;
    localparam logic [31:0] c_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_hold_buf
// Brief    : One-entry instruction/PC skid buffer used while ID is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module if_hold_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr
);

    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_addr <= i_addr;
        end
    end

    assign o_data = r_data;
    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Req/ack instruction fetch controller feeding IF/ID, driving PC write.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                DATA_W   = c_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INST = c_NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_write_o,
    input  logic              hazard_stall_i,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_req;
    logic              r_drop;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] w_buf_data;
    logic [ADDR_W-1:0] w_buf_addr;

    logic w_active;
    logic w_flush;
    logic w_ack_wait;
    logic w_keep;
    logic w_deliver_mem;
    logic w_to_hold;
    logic w_deliver_buf;
    logic w_latch;

    assign w_active      = (r_state != IDLE);
    assign w_flush       = w_active && flush_i;
    assign w_ack_wait    = (r_state == WAIT) && imem_ack_i;
    // Data returned for a request that was overtaken by a branch is dropped.
    assign w_keep        = w_ack_wait && !r_drop && !flush_i;
    assign w_deliver_mem = w_keep && !hazard_stall_i;
    assign w_to_hold     = w_keep && hazard_stall_i;
    assign w_deliver_buf = (r_state == HOLD) && !flush_i && !hazard_stall_i;
    assign w_latch       = (r_state == ISSUE) && start_i && !flush_i;

    assign pc_write_o = w_active &&
                        (flush_i ||
                         (w_ack_wait && !r_drop && !hazard_stall_i) ||
                         ((r_state == HOLD) && !hazard_stall_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (flush_i)      w_state_nxt = ISSUE;
                else if (start_i) w_state_nxt = WAIT;
                else              w_state_nxt = IDLE;
            end
            WAIT: begin
                if (imem_ack_i) w_state_nxt = w_to_hold ? HOLD : ISSUE;
            end
            HOLD: begin
                if (flush_i || !hazard_stall_i) w_state_nxt = ISSUE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_latch) begin
                r_req  <= 1'b1;
                r_addr <= pc_i;
            end else if (w_ack_wait) begin
                r_req  <= 1'b0;
            end
            if (w_ack_wait)                         r_drop <= 1'b0;
            else if ((r_state == WAIT) && flush_i)  r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_inst    <= NOP_INST;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else if (w_flush) begin
            r_inst    <= NOP_INST;
            r_valid   <= 1'b0;
        end else if (w_deliver_mem) begin
            r_inst    <= imem_rdata_i;
            r_inst_pc <= r_addr;
            r_valid   <= 1'b1;
        end else if (w_deliver_buf) begin
            r_inst    <= w_buf_data;
            r_inst_pc <= w_buf_addr;
            r_valid   <= 1'b1;
        end else if (!hazard_stall_i) begin
            r_inst    <= NOP_INST;
            r_valid   <= 1'b0;
        end
    end

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_to_hold),
        .i_clear (w_flush),
        .i_data  (imem_rdata_i),
        .i_addr  (r_addr),
        .o_data  (w_buf_data),
        .o_addr  (w_buf_addr)
    );

    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_addr;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Directed scoreboard bench for the instruction-fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        pc_write_o;
    logic        hazard_stall_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;

    always #5 clk_i = ~clk_i;

    if_fetch_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .pc_i           (pc_i),
        .pc_write_o     (pc_write_o),
        .hazard_stall_i (hazard_stall_i),
        .flush_i        (flush_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_valid_o   (inst_valid_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an instruction is accepted on an edge where PC write fires without a flush
    initial begin
        logic        deliver;
        logic [63:0] e;
        forever begin
            @(posedge clk_i);
            deliver = rst_i && pc_write_o && !flush_i;
            #1;
            if (deliver) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_delivery", inst_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst", inst_o, e[63:32]);
                    chk("mon_inst_pc", inst_pc_o, e[31:0]);
                    chk("mon_valid", 32'(inst_valid_o), 32'd1);
                end
            end else if (inst_valid_o && !prev_valid) begin
                chk("mon_spurious_valid", 32'(inst_valid_o), 32'd0);
            end
            prev_valid = inst_valid_o;
        end
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; pc_i = '0; hazard_stall_i = 1'b0;
        flush_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_req",      32'(imem_req_o),   32'd0);
        chk("rst_addr",     imem_addr_o,       32'h0);
        chk("rst_inst",     inst_o,            32'h0);
        chk("rst_inst_pc",  inst_pc_o,         32'h0);
        chk("rst_valid",    32'(inst_valid_o), 32'd0);
        chk("rst_pc_write", 32'(pc_write_o),   32'd0);

        // Zero-wait fetch at pc 0
        @(negedge clk_i); rst_i = 1'b1; start_i = 1'b1; pc_i = 32'h0;
        @(negedge clk_i); #1;
        chk("t1_issue_pcw", 32'(pc_write_o), 32'd0);
        chk("t1_issue_req", 32'(imem_req_o), 32'd0);
        @(negedge clk_i);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h2002_0005;
        exp_q.push_back({32'h2002_0005, 32'h0});
        #1;
        chk("t1_req",  32'(imem_req_o), 32'd1);
        chk("t1_addr", imem_addr_o,     32'h0);
        chk("t1_pcw",  32'(pc_write_o), 32'd1);
        @(negedge clk_i); imem_ack_i = 1'b0; pc_i = 32'h4; #1;
        chk("t1_pcw_once", 32'(pc_write_o), 32'd0);

        // Ack delayed three cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i == 3) begin
                imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_1111;
                exp_q.push_back({32'h0000_1111, 32'h4});
            end
            #1;
            chk("t2_req",  32'(imem_req_o), 32'd1);
            chk("t2_addr", imem_addr_o,     32'h4);
            chk("t2_pcw",  32'(pc_write_o), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk_i); imem_ack_i = 1'b0; pc_i = 32'h8; hazard_stall_i = 1'b1; #1;
        chk("t2_pcw_after", 32'(pc_write_o), 32'd0);
        chk("t2_req_after", 32'(imem_req_o), 32'd0);

        // Hazard stall at ack: HOLD, then release
        @(negedge clk_i); imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_3333; #1;
        chk("t3_addr",      imem_addr_o, 32'h8);
        chk("t3_pcw_ack",   32'(pc_write_o), 32'd0);
        chk("t3_inst_kept", inst_o, 32'h0000_1111);
        @(negedge clk_i); imem_ack_i = 1'b0; #1;
        chk("t3_pcw_hold",  32'(pc_write_o), 32'd0);
        chk("t3_hold_inst", inst_o, 32'h0000_1111);
        chk("t3_hold_pc",   inst_pc_o, 32'h4);
        @(negedge clk_i); hazard_stall_i = 1'b0;
        exp_q.push_back({32'h0000_3333, 32'h8});
        #1;
        chk("t3_pcw_release", 32'(pc_write_o), 32'd1);
        @(negedge clk_i); pc_i = 32'hC; #1;
        chk("t3_pcw_once", 32'(pc_write_o), 32'd0);

        // Flush in WAIT before ack; late data dropped
        @(negedge clk_i); flush_i = 1'b1; #1;
        chk("t4_req",  32'(imem_req_o), 32'd1);
        chk("t4_addr", imem_addr_o,     32'hC);
        chk("t4_pcw",  32'(pc_write_o), 32'd1);
        @(negedge clk_i);
        flush_i = 1'b0; pc_i = 32'h40; imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
        chk("t4_req_held",  32'(imem_req_o), 32'd1);
        chk("t4_addr_held", imem_addr_o,     32'hC);
        chk("t4_pcw_drop",  32'(pc_write_o), 32'd0);
        chk("t4_valid",     32'(inst_valid_o), 32'd0);
        @(negedge clk_i); imem_ack_i = 1'b0; #1;
        chk("t4_valid_dropped", 32'(inst_valid_o), 32'd0);
        chk("t4_req_dropped",   32'(imem_req_o), 32'd0);
        @(negedge clk_i); #1;
        chk("t4_new_req",  32'(imem_req_o), 32'd1);
        chk("t4_new_addr", imem_addr_o,     32'h40);

        // Flush coincident with ack and stall
        @(negedge clk_i); imem_ack_i = 1'b1; imem_rdata_i = 32'hC55C_0001;
        exp_q.push_back({32'hC55C_0001, 32'h40});
        #1;
        chk("t5_pcw_deliver", 32'(pc_write_o), 32'd1);
        @(negedge clk_i); imem_ack_i = 1'b0; pc_i = 32'h44; hazard_stall_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b1; flush_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD; #1;
        chk("t5_held_inst",  inst_o, 32'hC55C_0001);
        chk("t5_held_valid", 32'(inst_valid_o), 32'd1);
        chk("t5_addr",       imem_addr_o, 32'h44);
        chk("t5_pcw_flush",  32'(pc_write_o), 32'd1);
        @(negedge clk_i); imem_ack_i = 1'b0; flush_i = 1'b0; pc_i = 32'h80; #1;
        chk("t5_valid", 32'(inst_valid_o), 32'd0);
        chk("t5_inst",  inst_o, 32'h0);
        chk("t5_req",   32'(imem_req_o), 32'd0);
        @(negedge clk_i); #1;
        chk("t5_no_hold_req",  32'(imem_req_o), 32'd1);
        chk("t5_no_hold_addr", imem_addr_o,     32'h80);

        // Asynchronous reset mid-WAIT
        @(negedge clk_i);
        hazard_stall_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'hEEEE_0080;
        exp_q.push_back({32'hEEEE_0080, 32'h80});
        #1;
        chk("t6_pcw", 32'(pc_write_o), 32'd1);
        @(negedge clk_i); imem_ack_i = 1'b0; pc_i = 32'h84; hazard_stall_i = 1'b1;
        @(negedge clk_i); #1;
        chk("t6_req_pre",   32'(imem_req_o),   32'd1);
        chk("t6_valid_pre", 32'(inst_valid_o), 32'd1);
        chk("t6_addr_pre",  imem_addr_o,       32'h84);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_async_req",   32'(imem_req_o),   32'd0);
        chk("t6_async_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_async_pcw",   32'(pc_write_o),   32'd0);
        chk("t6_async_addr",  imem_addr_o,       32'h0);
        @(negedge clk_i); rst_i = 1'b1; hazard_stall_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hF00D_0084;
        exp_q.push_back({32'hF00D_0084, 32'h84});
        #1;
        chk("t6_restart_req",  32'(imem_req_o), 32'd1);
        chk("t6_restart_addr", imem_addr_o,     32'h84);
        @(negedge clk_i); imem_ack_i = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_req",         32'(imem_req_o),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
